// File: rtl/if_id_queue_pkg.sv
// Shared pipeline constants for the fetch/decode boundary: bus widths, enable
// polarities and the reset value of the decode-facing instruction word.
package if_id_queue_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;
    localparam int STALL_W     = 6;

    localparam logic RST_ENABLE    = 1'b1;
    localparam logic CHIP_ENABLE   = 1'b1;
    localparam logic STALL_ENABLE  = 1'b1;
    localparam logic STALL_DISABLE = 1'b0;

    localparam logic [INST_ADDR_W-1:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [INST_W-1:0]      NOP_INST  = 32'h0000_0000;

    // Positions within the stall vector driven by the stall controller.
    localparam int STALL_PC_BIT = 0;
    localparam int STALL_ID_BIT = 1;

endpackage

// File: rtl/if_id_queue_sync_fifo.sv
// Generic synchronous FIFO: storage, wrapping pointers and occupancy count.
// Read data is the registered head (no bypass); push while full only lands with a same-cycle pop.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push_vld,
    input  logic             pop_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);
    import if_id_queue_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop_vld && !empty;
    assign push_ok = push_vld && (!full || pop_ok);
    assign rd_dat  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = wr_dat;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            // Matched push+pop leaves occupancy untouched.
            if (push_ok && !pop_ok) begin
                count_d = count_q + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only valid entries are ever presented.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode queue: captures each advancing (pc, inst) pair; head visible one cycle after push.
// Raises stallreq_if when full so the PC holds; a push into a full queue without a pop is dropped and flagged.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = INST_ADDR_W,
    parameter int DATA_W = INST_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  if_pc,
    input  logic               if_ce,
    input  logic [DATA_W-1:0]  if_inst,
    input  logic [STALL_W-1:0] ctrl_stall,
    input  logic               flush,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [DATA_W-1:0]  id_inst,
    output logic               id_valid,
    output logic               stallreq_if,
    output logic               ovf_err
);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } fetch_t;

    fetch_t wr_dat;
    fetch_t rd_dat;
    logic   push_vld;
    logic   pop_vld;
    logic   fifo_full;
    logic   fifo_empty;
    logic   ovf_err_q, ovf_err_d;
    logic   unused_stall_bits;

    // Push mirrors the PC-advance condition, so every fetched pc lands exactly once.
    assign push_vld = (if_ce == CHIP_ENABLE)
                   && (ctrl_stall[STALL_PC_BIT] == STALL_DISABLE) && !flush;
    assign pop_vld  = id_valid
                   && (ctrl_stall[STALL_ID_BIT] == STALL_DISABLE) && !flush;

    assign wr_dat.pc   = if_pc;
    assign wr_dat.inst = if_inst;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_t))
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush),
        .push_vld (push_vld),
        .pop_vld  (pop_vld),
        .wr_dat   (wr_dat),
        .rd_dat   (rd_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign id_valid    = !fifo_empty;
    assign id_pc       = id_valid ? rd_dat.pc   : ADDR_W'(ZERO_WORD);
    assign id_inst     = id_valid ? rd_dat.inst : DATA_W'(NOP_INST);
    assign stallreq_if = fifo_full;
    assign ovf_err     = ovf_err_q;

    // Sticky until reset; flush deliberately leaves it set.
    always_comb begin
        ovf_err_d = ovf_err_q;
        if (push_vld && fifo_full && !pop_vld) begin
            ovf_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            ovf_err_q <= 1'b0;
        end else begin
            ovf_err_q <= ovf_err_d;
        end
    end

    assign unused_stall_bits = ^ctrl_stall[STALL_W-1:2];

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: streaming, ID stall to full, full push+pop,
// overflow, flush and mid-stream reset, each against hand-computed values.
module tb_if_id_queue;
    import if_id_queue_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        if_pc;
    logic               if_ce;
    logic [31:0]        if_inst;
    logic [STALL_W-1:0] ctrl_stall;
    logic               flush;
    logic [31:0]        id_pc;
    logic [31:0]        id_inst;
    logic               id_valid;
    logic               stallreq_if;
    logic               ovf_err;

    int checks   = 0;
    int failures = 0;

    if_id_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_pc       (if_pc),
        .if_ce       (if_ce),
        .if_inst     (if_inst),
        .ctrl_stall  (ctrl_stall),
        .flush       (flush),
        .id_pc       (id_pc),
        .id_inst     (id_inst),
        .id_valid    (id_valid),
        .stallreq_if (stallreq_if),
        .ovf_err     (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input logic ce, input logic [31:0] pc, input logic [1:0] stall);
        if_ce      = ce;
        if_pc      = pc;
        if_inst    = 32'h1000 + pc;
        ctrl_stall = {4'b0000, stall};
    endtask

    task automatic head(input string tag, input logic v, input logic [31:0] pc, input logic sreq);
        chk({tag, "_valid"}, {31'd0, id_valid}, {31'd0, v});
        chk({tag, "_pc"}, id_pc, pc);
        chk({tag, "_inst"}, id_inst, v ? 32'h1000 + pc : 32'h0);
        chk({tag, "_stallreq"}, {31'd0, stallreq_if}, {31'd0, sreq});
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        fetch(1'b0, 32'h0, 2'b00);
        tick();
        tick();
        head("reset", 1'b0, 32'h0, 1'b0);
        chk("reset_ovf", {31'd0, ovf_err}, 32'd0);

        // Streaming with no stalls: one entry in steady state, lagging by one cycle.
        rst = 1'b0;
        fetch(1'b1, 32'h0, 2'b00);
        chk("stream_pre_valid", {31'd0, id_valid}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            fetch(1'b1, 32'(4 * i), 2'b00);
            tick();
            head("stream", 1'b1, 32'(4 * i), 1'b0);
        end
        fetch(1'b0, 32'h0, 2'b00);
        tick();
        head("stream_drain", 1'b0, 32'h0, 1'b0);

        // ID stall: fill to four entries, head stays at pc 0.
        fetch(1'b1, 32'h0, 2'b10); tick(); head("idst1", 1'b1, 32'h0, 1'b0);
        fetch(1'b1, 32'h4, 2'b10); tick(); head("idst2", 1'b1, 32'h0, 1'b0);
        fetch(1'b1, 32'h8, 2'b10); tick(); head("idst3", 1'b1, 32'h0, 1'b0);
        fetch(1'b1, 32'hC, 2'b10); tick(); head("idst4", 1'b1, 32'h0, 1'b1);
        fetch(1'b1, 32'h10, 2'b11); tick(); head("idst5", 1'b1, 32'h0, 1'b1);
        chk("idst_ovf", {31'd0, ovf_err}, 32'd0);
        fetch(1'b1, 32'h10, 2'b01); tick(); head("rel1", 1'b1, 32'h4, 1'b0);
        fetch(1'b0, 32'h10, 2'b00); tick(); head("rel2", 1'b1, 32'h8, 1'b0);
        tick(); head("rel3", 1'b1, 32'hC, 1'b0);
        tick(); head("rel4", 1'b0, 32'h0, 1'b0);

        // Full queue with matched push and pop keeps count at four.
        fetch(1'b1, 32'h20, 2'b10); tick();
        fetch(1'b1, 32'h24, 2'b10); tick();
        fetch(1'b1, 32'h28, 2'b10); tick();
        fetch(1'b1, 32'h2C, 2'b10); tick(); head("full", 1'b1, 32'h20, 1'b1);
        fetch(1'b1, 32'h30, 2'b00); tick(); head("pp1", 1'b1, 32'h24, 1'b1);
        fetch(1'b1, 32'h34, 2'b00); tick(); head("pp2", 1'b1, 32'h28, 1'b1);
        chk("pp_ovf", {31'd0, ovf_err}, 32'd0);

        // Overflow: forced push while full and ID stalled is dropped.
        fetch(1'b1, 32'h38, 2'b10); tick(); head("ovf", 1'b1, 32'h28, 1'b1);
        chk("ovf_set", {31'd0, ovf_err}, 32'd1);
        fetch(1'b0, 32'h0, 2'b00); tick(); head("ovf_dr1", 1'b1, 32'h2C, 1'b0);
        tick(); head("ovf_dr2", 1'b1, 32'h30, 1'b0);
        tick(); head("ovf_dr3", 1'b1, 32'h34, 1'b0);
        tick(); head("ovf_dr4", 1'b0, 32'h0, 1'b0);

        // Flush with three entries and a same-cycle push.
        fetch(1'b1, 32'h50, 2'b10); tick();
        fetch(1'b1, 32'h54, 2'b10); tick();
        fetch(1'b1, 32'h58, 2'b10); tick(); head("pre_flush", 1'b1, 32'h50, 1'b0);
        flush = 1'b1;
        fetch(1'b1, 32'h5C, 2'b00); tick(); head("flush", 1'b0, 32'h0, 1'b0);
        chk("flush_ovf_held", {31'd0, ovf_err}, 32'd1);
        flush = 1'b0;
        fetch(1'b1, 32'h40, 2'b10); tick(); head("post_flush", 1'b1, 32'h40, 1'b0);
        fetch(1'b0, 32'h0, 2'b00); tick(); head("post_flush_alone", 1'b0, 32'h0, 1'b0);

        // Reset with two entries while pushing.
        fetch(1'b1, 32'h60, 2'b10); tick();
        fetch(1'b1, 32'h64, 2'b10); tick(); head("pre_rst", 1'b1, 32'h60, 1'b0);
        rst = 1'b1;
        fetch(1'b1, 32'h68, 2'b00); tick(); head("rst_mid", 1'b0, 32'h0, 1'b0);
        chk("rst_mid_ovf", {31'd0, ovf_err}, 32'd0);
        rst = 1'b0;
        fetch(1'b0, 32'h6C, 2'b00); tick(); head("ce_low", 1'b0, 32'h0, 1'b0);
        fetch(1'b1, 32'h70, 2'b00); tick(); head("ce_high", 1'b1, 32'h70, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
